led_pattern_monitor: RTL and testbench
======================================

Name: led_pattern_monitor

Overview:
Passive checker on the 8-bit LED bus driven by the progressive fill/drain LED controller.
It samples the bus on every clk50M edge and decodes which mode is running and which step is displayed.
It flags any illegal pattern transition and counts completed cycles.
It sits beside the controller in the top level and in benches, and drives only status outputs.

Parameters:
STEP_TICKS, 50_000_000, nominal clk50M cycles per LED step; used only with the optional feature.
TOL_TICKS, 1000, allowed +/- deviation of the step interval; used only with the optional feature.
CNT_W, 16, width of the completed-cycle counter.

Ports:
clk50M  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
led  in  8  LED bus under observation; same clock domain, so no synchroniser
locked  out  1  1 while a legal sequence is being tracked
mode_det  out  1  decoded mode: 0 = LSB-first fill/drain, 1 = MSB-first fill/drain
step  out  4  current step index, 0..15
cycle_cnt  out  CNT_W  completed 16-step cycles; saturates at all-ones
mode_sw  out  1  one-cycle pulse when a legal mode change is accepted
err  out  1  one-cycle pulse on an illegal transition (pattern or timing)
err_cnt  out  8  error count; saturates at 255
fault  out  1  sticky after the first err; cleared only by reset

Behaviour:
- Pattern table P(m, s), s = 0..15:
  - Mode 0, s = 0..8: (1<<s)-1, giving 00, 01, 03, ..., FF.
  - Mode 0, s = 9..15: (FF<<(s-8)) & FF, giving FE, FC, ..., 80.
  - Mode 1: bit-reverse of mode 0, giving 00, 80, C0, ..., FF, 7F, 3F, ..., 01.
  - Step 15 is followed by step 0 (00).
- Input register led_q <= led every cycle. chg = (led != led_q). All decisions use the registered values.
- Reset (synchronous, dominates every other event):
  - led_q = 00, state = SEARCH.
  - locked = 0, mode_det = 0, step = 0, cycle_cnt = 0, err_cnt = 0, fault = 0.
  - mode_sw = 0, err = 0.
  - Reset asserted mid-sequence clears all of the above on the next edge.
- FSM states: SEARCH, TRACK.
- SEARCH:
  - Ignore chg until led_q = 00.
  - Then, on the next chg:
    - new value 01: mode_det = 0, step = 1, go to TRACK.
    - new value 80: mode_det = 1, step = 1, go to TRACK.
    - any other value: stay in SEARCH; no error is raised.
- TRACK, on chg, in priority order:
  - (a) new value == P(mode_det, step+1 mod 16): step increments. On the 15 -> 0 wrap, cycle_cnt increments (saturating).
  - (b) step == 0 and new value == P(!mode_det, 1): mode_det toggles, step = 1, mode_sw pulses. A mode change is legal only at 00.
  - (c) otherwise: err pulses, err_cnt increments (saturating), fault = 1, go to SEARCH, step = 0.
- TRACK, no chg: hold.
- locked = (state == TRACK).
- Latency: status outputs update 2 edges after the led change (input register plus state register).
- Multi-bit jumps, e.g. 03 -> 0F, are errors.
- A change back to the previous pattern is an error.
- 00 in the middle of a cycle is an error.

Optional Feature:
LED_PERIOD_CHECK_EN.
- Defined:
  - A timer counts cycles since the last chg while in TRACK.
  - On chg, if the interval < STEP_TICKS-TOL_TICKS or > STEP_TICKS+TOL_TICKS, apply action (c).
  - Timer reaching STEP_TICKS+TOL_TICKS+1 with no chg also applies action (c): stall detection.
  - The timer resets on every chg and on entry to TRACK.
  - The first interval after lock is not checked.
- Not defined: no timer logic is built; only pattern checks apply. Ports are unchanged.

Decomposition:
- Package led_mon_pkg:
  - STEP_COUNT = 16.
  - State encoding constants SEARCH and TRACK.
  - Function for the pattern table P(m, s).
- Sub-module led_pattern_lut: combinational, (mode, step) -> expected 8-bit pattern.
  - The FSM instantiates it twice: current mode at step+1, and the other mode at step 1.

Test Plan:
- Mode 0 full cycle, each step held 10 clks (STEP_TICKS=10, TOL_TICKS=2): led 00, 01, 03, ..., FF, FE, ..., 80, 00 -> locked=1, mode_det=0, step ends at 0, cycle_cnt=1, err never pulses.
- Mode 1 from reset: led 00, 80, C0 -> mode_det=1, step=2. Continue 2 full cycles -> cycle_cnt=2.
- Mode switch at boundary: mode 0 cycle ends at 00, then 80 -> mode_sw one pulse, mode_det=1, step=1. Switch attempted at 03 -> 80 instead -> err pulse, err_cnt=1, fault=1, locked=0.
- Illegal jump in mode 0: 07 -> 3F -> err, fault=1, locked=0. Then 00, 01 -> relock with step=1; fault stays 1.
- Reset mid-track at step 5 -> next edge: all outputs zero. Then 00, 01 -> locked=1, step=1.
- With LED_PERIOD_CHECK_EN (STEP_TICKS=10, TOL_TICKS=2): a step held 5 clks -> err. A step held 13 clks with no change -> err at timer 13. Steps held 9 clks -> no err.

Source files
------------

// File: rtl/led_mon_pkg.sv
// led_mon_pkg
// Shared definitions for the LED pattern monitor: step count, FSM state
// encoding and the reference pattern table of the fill/drain LED controller.
// No ports; imported by led_pattern_lut and led_pattern_monitor.
package led_mon_pkg;

  localparam int STEP_COUNT = 16;
  localparam int STEP_W     = $clog2(STEP_COUNT);

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  // Mode 0 fills from the LSB (00, 01, 03 .. FF) and then drains from the
  // LSB (FE, FC .. 80). Mode 1 is the bit-reversed image of mode 0.
  function automatic logic [7:0] led_pattern(input logic mode, input logic [STEP_W-1:0] s);
    logic [8:0] fill;
    logic [7:0] p;
    logic [7:0] r;
    fill = (9'd1 << s) - 9'd1;
    if (s <= STEP_W'(8)) begin
      p = fill[7:0];
    end else begin
      p = 8'hFF << (s - STEP_W'(8));
    end
    for (int i = 0; i < 8; i++) begin
      r[i] = p[7-i];
    end
    return mode ? r : p;
  endfunction

endpackage

// File: rtl/led_pattern_lut.sv
// led_pattern_lut
// Combinational lookup of the expected LED pattern for a (mode, step) pair.
// Ports:
//   mode    - 0 = LSB-first fill/drain, 1 = MSB-first fill/drain
//   step    - step index 0..15
//   pattern - expected 8-bit LED value
import led_mon_pkg::*;

module led_pattern_lut (
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  output logic [7:0]        pattern
);

  assign pattern = led_pattern(mode, step);

endmodule

// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor
// Passive checker on the 8-bit LED bus of the progressive fill/drain LED
// controller. Decodes the running mode and step, flags illegal transitions
// and counts completed 16-step cycles.
// Optional feature: define LED_PERIOD_CHECK_EN to also check the interval
// between LED changes against STEP_TICKS +/- TOL_TICKS (including stall
// detection). Without it no timer is built and only patterns are checked.
// Ports:
//   clk50M    - 50 MHz system clock
//   reset     - synchronous, active-high reset
//   led       - LED bus under observation (same clock domain)
//   locked    - 1 while a legal sequence is being tracked
//   mode_det  - decoded mode (0 = LSB-first, 1 = MSB-first)
//   step      - current step index 0..15
//   cycle_cnt - completed cycles, saturating
//   mode_sw   - one-cycle pulse on an accepted mode change
//   err       - one-cycle pulse on an illegal transition
//   err_cnt   - error count, saturating at 255
//   fault     - sticky error flag, cleared only by reset
import led_mon_pkg::*;

module led_pattern_monitor #(
  parameter int unsigned STEP_TICKS = 50_000_000,
  parameter int unsigned TOL_TICKS  = 1000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk50M,
  input  logic             reset,
  input  logic [7:0]       led,
  output logic             locked,
  output logic             mode_det,
  output logic [3:0]       step,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             mode_sw,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic             fault
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_COUNT - 1);

  // A tolerance as wide as the step would make the lower interval bound meaningless.
  if (TOL_TICKS >= STEP_TICKS) begin : g_bad_tol
    $error("led_pattern_monitor: TOL_TICKS must be smaller than STEP_TICKS");
  end

  logic [7:0]        led_q;
  logic [7:0]        led_prev;
  logic              chg;
  state_t            state;
  state_t            state_n;
  logic              mode_n;
  logic [STEP_W-1:0] step_n;
  logic [STEP_W-1:0] step_inc;
  logic [CNT_W-1:0]  cyc_n;
  logic [7:0]        errc_n;
  logic              fault_n;
  logic              sw_n;
  logic              err_n;
  logic              bad;
  logic [7:0]        exp_next;
  logic [7:0]        exp_sw;

`ifdef LED_PERIOD_CHECK_EN
  localparam int TW = $clog2(STEP_TICKS + TOL_TICKS + 2);
  localparam logic [TW-1:0] MIN_T = TW'(STEP_TICKS - TOL_TICKS);
  localparam logic [TW-1:0] MAX_T = TW'(STEP_TICKS + TOL_TICKS);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic          first_iv;
  logic          first_n;
`endif

  // led_q is the registered bus; led_prev is the value it held one cycle
  // earlier, so a change is seen as a difference between the two registers.
  assign chg      = (led_q != led_prev);
  assign step_inc = step + 1'b1;
  assign locked   = (state == TRACK);

  led_pattern_lut u_lut_next (
    .mode    (mode_det),
    .step    (step_inc),
    .pattern (exp_next)
  );

  led_pattern_lut u_lut_sw (
    .mode    (~mode_det),
    .step    (STEP_W'(1)),
    .pattern (exp_sw)
  );

  // Next-state and status decode. Pattern actions are resolved first; any
  // violation (pattern or timing) then overrides them with the error action.
  always_comb begin
    state_n = state;
    mode_n  = mode_det;
    step_n  = step;
    cyc_n   = cycle_cnt;
    errc_n  = err_cnt;
    fault_n = fault;
    sw_n    = 1'b0;
    err_n   = 1'b0;
    bad     = 1'b0;
`ifdef LED_PERIOD_CHECK_EN
    timer_n = timer;
    first_n = first_iv;
`endif

    case (state)
      SEARCH: begin
        // Only a change leaving an all-off bus can start a sequence.
        if (chg && (led_prev == 8'h00)) begin
          if (led_q == 8'h01) begin
            state_n = TRACK;
            mode_n  = 1'b0;
            step_n  = STEP_W'(1);
          end else if (led_q == 8'h80) begin
            state_n = TRACK;
            mode_n  = 1'b1;
            step_n  = STEP_W'(1);
          end
        end
      end
      TRACK: begin
        if (chg) begin
          if (led_q == exp_next) begin
            step_n = step_inc;
            if ((step == LAST_STEP) && (cycle_cnt != {CNT_W{1'b1}})) begin
              cyc_n = cycle_cnt + 1'b1;
            end
          end else if ((step == '0) && (led_q == exp_sw)) begin
            mode_n = ~mode_det;
            step_n = STEP_W'(1);
            sw_n   = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase

`ifdef LED_PERIOD_CHECK_EN
    // The timer holds the number of cycles since the last change; the first
    // interval after locking is unchecked because its start was not timed.
    if (state == TRACK) begin
      if (chg) begin
        if (!first_iv && ((timer < MIN_T) || (timer > MAX_T))) begin
          bad = 1'b1;
        end
      end else if (timer > MAX_T) begin
        bad = 1'b1;
      end
    end
    if (chg || (state == SEARCH)) begin
      timer_n = TW'(1);
    end else if (timer <= MAX_T) begin
      timer_n = timer + TW'(1);
    end
    if (state == SEARCH) begin
      first_n = 1'b1;
    end else if (chg) begin
      first_n = 1'b0;
    end
`endif

    if (bad) begin
      err_n   = 1'b1;
      fault_n = 1'b1;
      state_n = SEARCH;
      step_n  = '0;
      sw_n    = 1'b0;
      mode_n  = mode_det;
      cyc_n   = cycle_cnt;
      if (err_cnt != 8'hFF) begin
        errc_n = err_cnt + 1'b1;
      end
    end
  end

  // State and status registers; reset dominates every other event.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      led_q     <= 8'h00;
      led_prev  <= 8'h00;
      state     <= SEARCH;
      mode_det  <= 1'b0;
      step      <= '0;
      cycle_cnt <= '0;
      err_cnt   <= 8'h00;
      fault     <= 1'b0;
      mode_sw   <= 1'b0;
      err       <= 1'b0;
`ifdef LED_PERIOD_CHECK_EN
      timer     <= TW'(1);
      first_iv  <= 1'b1;
`endif
    end else begin
      led_q     <= led;
      led_prev  <= led_q;
      state     <= state_n;
      mode_det  <= mode_n;
      step      <= step_n;
      cycle_cnt <= cyc_n;
      err_cnt   <= errc_n;
      fault     <= fault_n;
      mode_sw   <= sw_n;
      err       <= err_n;
`ifdef LED_PERIOD_CHECK_EN
      timer     <= timer_n;
      first_iv  <= first_n;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_monitor.sv
// tb_led_pattern_monitor
// Scoreboard bench for led_pattern_monitor. Each LED stimulus pushes its
// expected status to a queue; after the step has been held the entry is
// popped and compared with the DUT outputs and with the pulses seen meanwhile.
// Timing scenarios are included when LED_PERIOD_CHECK_EN is defined.
module tb_led_pattern_monitor;

  logic        clk50M;
  logic        reset;
  logic [7:0]  led;
  logic        locked;
  logic        mode_det;
  logic [3:0]  step;
  logic [15:0] cycle_cnt;
  logic        mode_sw;
  logic        err;
  logic [7:0]  err_cnt;
  logic        fault;

  typedef struct {
    string tag;
    logic  lk;
    logic  md;
    int    st;
    int    cyc;
    int    errc;
    logic  flt;
    int    nerr;
    int    nsw;
  } exp_t;

  exp_t sb[$];

  int checks;
  int errors;
  int errSeen;
  int swSeen;
  int eCyc;
  int eErrc;
  logic eFlt;

  // Independent reference tables of the controller patterns.
  logic [7:0] pat0 [16];
  logic [7:0] pat1 [16];

  led_pattern_monitor #(
    .STEP_TICKS (10),
    .TOL_TICKS  (2),
    .CNT_W      (16)
  ) dut (
    .clk50M    (clk50M),
    .reset     (reset),
    .led       (led),
    .locked    (locked),
    .mode_det  (mode_det),
    .step      (step),
    .cycle_cnt (cycle_cnt),
    .mode_sw   (mode_sw),
    .err       (err),
    .err_cnt   (err_cnt),
    .fault     (fault)
  );

  // 50 MHz clock
  initial begin
    clk50M = 1'b0;
    forever #10 clk50M = ~clk50M;
  end

  // Count the one-cycle pulses between stimulus and comparison.
  always @(negedge clk50M) begin
    if (err === 1'b1) errSeen = errSeen + 1;
    if (mode_sw === 1'b1) swSeen = swSeen + 1;
  end

  // Compare one observed value against the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic scoreCompare();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, ".locked"},  32'(locked),    32'(e.lk));
    checkOutput({e.tag, ".mode"},    32'(mode_det),  32'(e.md));
    checkOutput({e.tag, ".step"},    32'(step),      32'(e.st));
    checkOutput({e.tag, ".cycles"},  32'(cycle_cnt), 32'(e.cyc));
    checkOutput({e.tag, ".err_cnt"}, 32'(err_cnt),   32'(e.errc));
    checkOutput({e.tag, ".fault"},   32'(fault),     32'(e.flt));
    checkOutput({e.tag, ".err_pulses"}, 32'(errSeen), 32'(e.nerr));
    checkOutput({e.tag, ".sw_pulses"},  32'(swSeen),  32'(e.nsw));
  endtask

  // Drive one LED value, hold it for 'hold' cycles, then score the result.
  task automatic applyStimulus(input string tag, input logic [7:0] v, input int hold,
                               input logic lk, input logic md, input int st,
                               input int nerr, input int nsw);
    exp_t e;
    e.tag = tag; e.lk = lk; e.md = md; e.st = st;
    e.cyc = eCyc; e.errc = eErrc; e.flt = eFlt; e.nerr = nerr; e.nsw = nsw;
    sb.push_back(e);
    errSeen = 0;
    swSeen  = 0;
    led = v;
    repeat (hold) @(posedge clk50M);
    #1;
    scoreCompare();
  endtask

  // Assert reset for one edge with the bus idle; everything must clear.
  task automatic applyReset(input string tag);
    exp_t e;
    eCyc = 0; eErrc = 0; eFlt = 1'b0;
    e.tag = tag; e.lk = 1'b0; e.md = 1'b0; e.st = 0;
    e.cyc = 0; e.errc = 0; e.flt = 1'b0; e.nerr = 0; e.nsw = 0;
    sb.push_back(e);
    reset = 1'b1;
    led   = 8'h00;
    @(posedge clk50M);
    #1;
    errSeen = 0;
    swSeen  = 0;
    scoreCompare();
    reset = 1'b0;
  endtask

  // Walk a mode from step 'from' through the wrap to step 0.
  task automatic runCycle(input string tag, input logic md, input int from);
    for (int s = from; s <= 16; s++) begin
      if (s == 16) eCyc = eCyc + 1;
      applyStimulus(tag, md ? pat1[s % 16] : pat0[s % 16], 10, 1'b1, md, s % 16, 0, 0);
    end
  endtask

  initial begin
    pat0 = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
             8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    pat1 = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
             8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    checks = 0; errors = 0; errSeen = 0; swSeen = 0;
    eCyc = 0; eErrc = 0; eFlt = 1'b0;
    reset = 1'b1;
    led   = 8'h00;
    @(posedge clk50M);
    #1;

    // Reset state, then an idle bus stays unlocked.
    applyReset("reset");
    applyStimulus("idle", 8'h00, 5, 1'b0, 1'b0, 0, 0, 0);

    // Mode 0 full cycle ending at 00.
    runCycle("m0_cycle", 1'b0, 1);

    // Legal mode switch at 00, then a full mode 1 cycle.
    applyStimulus("sw_to_m1", 8'h80, 10, 1'b1, 1'b1, 1, 0, 1);
    runCycle("m1_cycle", 1'b1, 2);

    // Switch back to mode 0, then a switch attempted at 03 is illegal.
    applyStimulus("sw_to_m0", 8'h01, 10, 1'b1, 1'b0, 1, 0, 1);
    applyStimulus("m0_s2", 8'h03, 10, 1'b1, 1'b0, 2, 0, 0);
    eErrc = 1; eFlt = 1'b1;
    applyStimulus("bad_switch", 8'h80, 10, 1'b0, 1'b0, 0, 1, 0);

    // Relock, then an illegal multi-bit jump 07 -> 3F.
    applyStimulus("search_00", 8'h00, 10, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus("relock", 8'h01, 10, 1'b1, 1'b0, 1, 0, 0);
    applyStimulus("relock_s2", 8'h03, 10, 1'b1, 1'b0, 2, 0, 0);
    applyStimulus("relock_s3", 8'h07, 10, 1'b1, 1'b0, 3, 0, 0);
    eErrc = 2;
    applyStimulus("jump", 8'h3F, 10, 1'b0, 1'b0, 0, 1, 0);

    // Relock, then a change back to the previous pattern.
    applyStimulus("search_00b", 8'h00, 10, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus("relock2", 8'h01, 10, 1'b1, 1'b0, 1, 0, 0);
    applyStimulus("relock2_s2", 8'h03, 10, 1'b1, 1'b0, 2, 0, 0);
    eErrc = 3;
    applyStimulus("back_step", 8'h01, 10, 1'b0, 1'b0, 0, 1, 0);

    // Relock and advance to step 5, then reset mid-track.
    applyStimulus("search_00c", 8'h00, 10, 1'b0, 1'b0, 0, 0, 0);
    for (int s = 1; s <= 5; s++) begin
      applyStimulus("to_s5", pat0[s], 10, 1'b1, 1'b0, s, 0, 0);
    end
    applyReset("mid_reset");
    applyStimulus("post_reset_00", 8'h00, 10, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus("post_reset_01", 8'h01, 10, 1'b1, 1'b0, 1, 0, 0);

    // Mode 1 from reset: 00, 80, C0, then two full cycles.
    applyReset("reset_m1");
    applyStimulus("m1_00", 8'h00, 10, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus("m1_80", 8'h80, 10, 1'b1, 1'b1, 1, 0, 0);
    applyStimulus("m1_C0", 8'hC0, 10, 1'b1, 1'b1, 2, 0, 0);
    runCycle("m1_first", 1'b1, 3);
    runCycle("m1_second", 1'b1, 1);

`ifdef LED_PERIOD_CHECK_EN
    // Intervals of 9 are inside 10 +/- 2; an interval of 5 is too short.
    applyStimulus("t_ok1", 8'h80, 9, 1'b1, 1'b1, 1, 0, 0);
    applyStimulus("t_ok2", 8'hC0, 9, 1'b1, 1'b1, 2, 0, 0);
    applyStimulus("t_ok3", 8'hE0, 5, 1'b1, 1'b1, 3, 0, 0);
    eErrc = eErrc + 1; eFlt = 1'b1;
    applyStimulus("t_short", 8'hF0, 10, 1'b0, 1'b1, 0, 1, 0);
    // Relock, then hold a step with no change until the stall limit.
    applyStimulus("t_search", 8'h00, 10, 1'b0, 1'b1, 0, 0, 0);
    applyStimulus("t_lock", 8'h80, 10, 1'b1, 1'b1, 1, 0, 0);
    eErrc = eErrc + 1;
    applyStimulus("t_stall", 8'hC0, 20, 1'b0, 1'b1, 0, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
